mdr_arbiter: RTL and testbench
==============================

Name: mdr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one iterative arithmetic datapath (operand registers X/Y, op select, start/done/error handshake) among NUM_REQ requesters.
- Accepts one request at a time, drives the operand-load / start sequence, and waits for done or error.
- Returns the result, error or timeout status to the granted requester.
- Sits between requester front-ends and the datapath, replacing a single-user control FSM.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, operand and result width.
- OP_W, 2, operation select width.
- TIMEOUT, 64, maximum WAIT_DONE cycles before abort (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_x  in  NUM_REQ*DATA_W  operand X, requester i at bits [i*DATA_W +: DATA_W].
- req_y  in  NUM_REQ*DATA_W  operand Y, same packing.
- req_op  in  NUM_REQ*OP_W  operation select, same packing.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- rsp_valid  out  NUM_REQ  one-hot response pulse.
- rsp_result  out  DATA_W  result; meaningful only while rsp_valid is nonzero.
- rsp_error  out  1  datapath reported error; qualified by rsp_valid.
- rsp_timeout  out  1  watchdog abort; qualified by rsp_valid.
- dp_operand  out  DATA_W  operand bus to datapath.
- dp_load_x  out  1  load X register from dp_operand.
- dp_load_y  out  1  load Y register from dp_operand.
- dp_op_sel  out  OP_W  operation select, held from LOAD_X through WAIT_DONE.
- dp_start  out  1  one-cycle start pulse.
- dp_done  in  1  datapath finished; result valid this cycle.
- dp_error  in  1  datapath rejected operands.
- dp_result  in  DATA_W  datapath result.

Behaviour:
- All outputs registered (Moore).
- Reset: state=IDLE, rr pointer=0, watchdog=0, every output 0. Reset mid-operation discards the job and issues no response.
- States: IDLE, LOAD_X, LOAD_Y, START, WAIT_DONE, RESPOND.
- IDLE, no req_valid: stay.
- IDLE, any req_valid: grant the first index at or after the rr pointer with req_valid=1, wrapping modulo NUM_REQ.
  - Capture that requester's x, y and op into internal registers.
  - Pulse req_ready[grant] for exactly one cycle (the accept cycle).
  - Go to LOAD_X.
- req_valid may drop before grant with no effect. The requester must hold operands valid in the cycle req_valid is high.
- LOAD_X (1 cycle): dp_load_x=1, dp_operand=captured x. Go to LOAD_Y.
- LOAD_Y (1 cycle): dp_load_y=1, dp_operand=captured y. Go to START.
- START (1 cycle): dp_start=1. Clear the watchdog. Go to WAIT_DONE.
- WAIT_DONE: the watchdog increments each cycle.
  - dp_error=1: go to RESPOND with error=1. Error wins over a simultaneous dp_done.
  - Else dp_done=1: capture dp_result, go to RESPOND.
  - Else watchdog=TIMEOUT-1: go to RESPOND with timeout=1, result 0.
- RESPOND (1 cycle):
  - rsp_valid[grant]=1, with rsp_result/rsp_error/rsp_timeout driven.
  - rr pointer = (grant+1) mod NUM_REQ.
  - Go to IDLE.
- Outside RESPOND: rsp_* = 0, dp_load_*/dp_start = 0, dp_operand = 0.
- dp_done/dp_error outside WAIT_DONE are ignored.
- Latency: accept in cycle 0 -> load_x in 1 -> load_y in 2 -> start in 3. dp_done first sampled in cycle 4; done in cycle k gives rsp_valid in cycle k+1.
- A new grant is at the earliest the cycle after RESPOND (IDLE). Throughput is one job per 6+N cycles.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 jobs.
- The rr pointer advances only on RESPOND, including error and timeout responses.

Test Plan:
- Single job: req_valid[2]=1, x=7, y=6, op=1; datapath returns done with 42 two cycles after start.
  - Required: req_ready[2] in cycle 0; load_x/load_y/start in cycles 1/2/3.
  - Required: rsp_valid[2]=1 with result=42, error=0 and timeout=0 one cycle after done.
- Round-robin: all four requesters valid continuously, pointer=0.
  - Required: grant order 0,1,2,3,0, with exactly one rsp_valid pulse per job.
- Error priority: dp_error and dp_done both high in the same WAIT_DONE cycle.
  - Required: rsp_error=1, rsp_timeout=0, and rr pointer still advances.
- Timeout: datapath never signals done, TIMEOUT=64.
  - Required: rsp_timeout=1 and rsp_result=0 exactly 64 cycles after the start pulse; then back to IDLE.
- Reset mid-operation: assert rst during WAIT_DONE.
  - Required: all outputs 0 immediately (asynchronous), no rsp_valid, pointer=0.
  - Required: the next request from requester 3 with requester 0 also valid grants 0 first.
- Spurious handshake: dp_done pulses while IDLE, and req_valid drops before grant.
  - Required: no state change and no response.

Source files
------------

// File: rtl/mdr_arbiter.sv
// mdr_arbiter: round-robin arbiter and sequencer that lets NUM_REQ requesters
// share one iterative arithmetic datapath (operand load, start, wait for
// done/error/timeout, return the response to the granted requester).
module mdr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int OP_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_x,
  input  logic [NUM_REQ*DATA_W-1:0] req_y,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_error,
  output logic                      rsp_timeout,
  output logic [DATA_W-1:0]         dp_operand,
  output logic                      dp_load_x,
  output logic                      dp_load_y,
  output logic [OP_W-1:0]           dp_op_sel,
  output logic                      dp_start,
  input  logic                      dp_done,
  input  logic                      dp_error,
  input  logic [DATA_W-1:0]         dp_result
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    START,
    WAIT_DONE,
    RESPOND
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_q;
  logic [IDX_W-1:0]  grant_d;
  logic              grant_found;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] y_q;
  logic [OP_W-1:0]   op_q;
  logic [WD_W-1:0]   wd;
  logic [DATA_W-1:0] rsp_result_d;
  logic              rsp_error_d;
  logic              rsp_timeout_d;

  // Pick the first valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_d     = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_d     = IDX_W'(idx);
      end
    end
  end

  // Next-state logic; the response fields are decided on the way into RESPOND.
  // The first WAIT_DONE cycle is the one in which dp_start is on the bus, so the
  // datapath cannot have answered yet and its handshake is not sampled then.
  always_comb begin
    next_state    = state;
    rsp_result_d  = '0;
    rsp_error_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    case (state)
      IDLE:      if (grant_found) next_state = LOAD_X;
      LOAD_X:    next_state = LOAD_Y;
      LOAD_Y:    next_state = START;
      START:     next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (wd != '0 && dp_error) begin
          next_state  = RESPOND;
          rsp_error_d = 1'b1;
        end else if (wd != '0 && dp_done) begin
          next_state   = RESPOND;
          rsp_result_d = dp_result;
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          next_state    = RESPOND;
          rsp_timeout_d = 1'b1;
        end
      end
      RESPOND:   next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // State, captured job, watchdog and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= '0;
      wd      <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && grant_found) begin
        grant_q <= grant_d;
        x_q     <= req_x[int'(grant_d)*DATA_W +: DATA_W];
        y_q     <= req_y[int'(grant_d)*DATA_W +: DATA_W];
        op_q    <= req_op[int'(grant_d)*OP_W +: OP_W];
      end
      if (state == START) begin
        wd <= '0;
      end else if (state == WAIT_DONE) begin
        wd <= wd + 1'b1;
      end
      if (state == RESPOND) begin
        rr_ptr <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

  // Registered outputs: accept pulse, datapath sequencing and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_result  <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      dp_operand  <= '0;
      dp_load_x   <= 1'b0;
      dp_load_y   <= 1'b0;
      dp_op_sel   <= '0;
      dp_start    <= 1'b0;
    end else begin
      req_ready   <= (state == IDLE && grant_found) ? (ONE << grant_d) : '0;
      dp_load_x   <= (state == LOAD_X);
      dp_load_y   <= (state == LOAD_Y);
      dp_start    <= (state == START);
      dp_operand  <= (state == LOAD_X) ? x_q : (state == LOAD_Y) ? y_q : '0;
      dp_op_sel   <= ((state inside {LOAD_X, LOAD_Y, START}) ||
                      (state == WAIT_DONE && next_state == WAIT_DONE)) ? op_q : '0;
      rsp_valid   <= (next_state == RESPOND) ? (ONE << grant_q) : '0;
      rsp_result  <= rsp_result_d;
      rsp_error   <= rsp_error_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_mdr_arbiter.sv
// tb_mdr_arbiter: scoreboard bench for mdr_arbiter with a small datapath model.
module tb_mdr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int OP_W    = 2;
  localparam int TIMEOUT = 64;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_x;
  logic [NUM_REQ*DATA_W-1:0] req_y;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_error;
  logic                      rsp_timeout;
  logic [DATA_W-1:0]         dp_operand;
  logic                      dp_load_x;
  logic                      dp_load_y;
  logic [OP_W-1:0]           dp_op_sel;
  logic                      dp_start;
  logic                      dp_done;
  logic                      dp_error;
  logic [DATA_W-1:0]         dp_result;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] result;
    logic              err;
    logic              tmo;
  } exp_t;
  exp_t sb[$];

  // Datapath model controls: mode 0 never answers, 1 done, 2 done+error.
  int          dp_mode;
  int          dp_delay;
  bit          spur_done;
  bit          spur_error;
  bit          busy;
  int          cnt;
  logic [DATA_W-1:0] lx;
  logic [DATA_W-1:0] ly;

  mdr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_op(req_op),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .dp_operand(dp_operand), .dp_load_x(dp_load_x), .dp_load_y(dp_load_y),
    .dp_op_sel(dp_op_sel), .dp_start(dp_start),
    .dp_done(dp_done), .dp_error(dp_error), .dp_result(dp_result)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "[TB] aborted");
  end

  function automatic logic [DATA_W-1:0] calc(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [OP_W-1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a * b;
      2'd2:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic int oh2idx(input logic [NUM_REQ-1:0] v);
    int n = 0;
    int r = -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) begin n++; r = i; end
    return (n == 1) ? r : -2;
  endfunction

  // Datapath model: latches loaded operands, answers dp_delay cycles after start.
  initial begin
    dp_done = 1'b0; dp_error = 1'b0; dp_result = '0;
    busy = 1'b0; cnt = 0; lx = '0; ly = '0;
    forever begin
      @(negedge clk);
      dp_done   = spur_done;
      dp_error  = spur_error;
      dp_result = '0;
      if (rst) begin
        busy = 1'b0;
      end else begin
        if (dp_load_x) lx = dp_operand;
        if (dp_load_y) ly = dp_operand;
        if (busy) begin
          cnt--;
          if (cnt <= 0) begin
            busy = 1'b0;
            if (dp_mode == 1) begin
              dp_done = 1'b1; dp_result = calc(lx, ly, dp_op_sel);
            end else if (dp_mode == 2) begin
              dp_done = 1'b1; dp_error = 1'b1; dp_result = 16'hdead;
            end
          end
        end
        if (dp_start) begin busy = 1'b1; cnt = dp_delay; end
      end
    end
  end

  task automatic set_req(input int i, input logic [DATA_W-1:0] x,
                         input logic [DATA_W-1:0] y, input logic [OP_W-1:0] op);
    req_x[i*DATA_W +: DATA_W] = x;
    req_y[i*DATA_W +: DATA_W] = y;
    req_op[i*OP_W +: OP_W]    = op;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    req_valid = '0;
    spur_done = 1'b0;
    spur_error = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sb.delete();
  endtask

  task automatic wait_ready(input int budget, output int idx);
    idx = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin idx = oh2idx(req_ready); break; end
    end
  endtask

  task automatic wait_rsp(input int budget, output int idx, output int cyc);
    idx = -1;
    cyc = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid != '0) begin idx = oh2idx(rsp_valid); break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_handshake: got ready=%b rsp=%b expected 0000 0000", req_ready, rsp_valid);
    end
    checks++;
    if ({rsp_result, rsp_error, rsp_timeout, dp_operand, dp_load_x, dp_load_y, dp_op_sel, dp_start} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got res=%h err=%b tmo=%b opnd=%h lx=%b ly=%b op=%b st=%b expected all 0",
               rsp_result, rsp_error, rsp_timeout, dp_operand, dp_load_x, dp_load_y, dp_op_sel, dp_start);
    end
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    exp_t e;
    apply_reset();
    dp_mode = 1; dp_delay = 2;
    set_req(2, 16'd7, 16'd6, 2'd1);
    req_valid = 4'b0100;
    sb.push_back('{idx: 2, result: 16'd42, err: 1'b0, tmo: 1'b0});
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("[TB] FAIL single_ready: got %b expected 0100", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (dp_load_x !== 1'b1 || dp_load_y !== 1'b0 || dp_operand !== 16'd7 || dp_op_sel !== 2'd1) begin
      errors++; $display("[TB] FAIL single_load_x: got lx=%b ly=%b opnd=%0d op=%0d expected 1 0 7 1", dp_load_x, dp_load_y, dp_operand, dp_op_sel);
    end
    @(negedge clk);
    checks++;
    if (dp_load_y !== 1'b1 || dp_load_x !== 1'b0 || dp_operand !== 16'd6) begin
      errors++; $display("[TB] FAIL single_load_y: got ly=%b lx=%b opnd=%0d expected 1 0 6", dp_load_y, dp_load_x, dp_operand);
    end
    @(negedge clk);
    checks++;
    if (dp_start !== 1'b1 || dp_load_y !== 1'b0 || dp_operand !== 16'd0) begin
      errors++; $display("[TB] FAIL single_start: got st=%b ly=%b opnd=%0d expected 1 0 0", dp_start, dp_load_y, dp_operand);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0000 || dp_start !== 1'b0) begin
      errors++; $display("[TB] FAIL single_early_rsp: got rsp=%b st=%b expected 0000 0", rsp_valid, dp_start);
    end
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("[TB] FAIL single_sb: got empty scoreboard expected 1 entry");
    end else begin
      e = sb.pop_front();
      if (oh2idx(rsp_valid) !== e.idx || rsp_result !== e.result || rsp_error !== e.err || rsp_timeout !== e.tmo) begin
        errors++;
        $display("[TB] FAIL single_rsp: got rsp=%b res=%0d err=%b tmo=%b expected req=%0d res=%0d err=%b tmo=%b",
                 rsp_valid, rsp_result, rsp_error, rsp_timeout, e.idx, e.result, e.err, e.tmo);
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++; $display("[TB] FAIL single_rsp_pulse: got %b expected 0000", rsp_valid);
    end
  endtask

  task automatic test_round_robin;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [DATA_W-1:0] tx[NUM_REQ];
    logic [DATA_W-1:0] ty[NUM_REQ];
    exp_t e;
    int g, gi, c;
    apply_reset();
    dp_mode = 1; dp_delay = 3;
    for (int i = 0; i < NUM_REQ; i++) begin
      tx[i] = DATA_W'(100 + i * 11);
      ty[i] = DATA_W'(3 + i);
      set_req(i, tx[i], ty[i], OP_W'(i));
    end
    for (int j = 0; j < 5; j++)
      sb.push_back('{idx: order[j], result: calc(tx[order[j]], ty[order[j]], OP_W'(order[j])), err: 1'b0, tmo: 1'b0});
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_ready(20, g);
      checks++;
      if (g != order[j]) begin
        errors++; $display("[TB] FAIL rr_grant%0d: got %0d expected %0d", j, g, order[j]);
      end
      wait_rsp(20, gi, c);
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("[TB] FAIL rr_sb%0d: got empty scoreboard expected entry", j);
      end else begin
        e = sb.pop_front();
        if (gi != e.idx || rsp_result !== e.result || rsp_error !== e.err || rsp_timeout !== e.tmo) begin
          errors++;
          $display("[TB] FAIL rr_rsp%0d: got req=%0d res=%0d err=%b tmo=%b expected req=%0d res=%0d err=%b tmo=%b",
                   j, gi, rsp_result, rsp_error, rsp_timeout, e.idx, e.result, e.err, e.tmo);
        end
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0000) begin
        errors++; $display("[TB] FAIL rr_pulse%0d: got %b expected 0000", j, rsp_valid);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_error_priority;
    exp_t e;
    int g, gi, c;
    apply_reset();
    dp_mode = 2; dp_delay = 2;
    set_req(0, 16'd9, 16'd9, 2'd1);
    req_valid = 4'b0001;
    sb.push_back('{idx: 0, result: 16'd0, err: 1'b1, tmo: 1'b0});
    wait_ready(5, g);
    req_valid = '0;
    wait_rsp(20, gi, c);
    checks++;
    e = sb.pop_front();
    if (gi != e.idx || rsp_error !== e.err || rsp_timeout !== e.tmo) begin
      errors++;
      $display("[TB] FAIL err_rsp: got req=%0d err=%b tmo=%b expected req=%0d err=%b tmo=%b",
               gi, rsp_error, rsp_timeout, e.idx, e.err, e.tmo);
    end
    dp_mode = 1;
    set_req(0, 16'd1, 16'd2, 2'd0);
    set_req(1, 16'd5, 16'd6, 2'd0);
    req_valid = 4'b0011;
    sb.push_back('{idx: 1, result: 16'd11, err: 1'b0, tmo: 1'b0});
    wait_ready(5, g);
    checks++;
    if (g != 1) begin
      errors++; $display("[TB] FAIL err_ptr_advance: got grant %0d expected 1", g);
    end
    req_valid = '0;
    wait_rsp(20, gi, c);
    checks++;
    e = sb.pop_front();
    if (gi != e.idx || rsp_result !== e.result || rsp_error !== e.err || rsp_timeout !== e.tmo) begin
      errors++;
      $display("[TB] FAIL err_next_rsp: got req=%0d res=%0d err=%b tmo=%b expected req=%0d res=%0d err=%b tmo=%b",
               gi, rsp_result, rsp_error, rsp_timeout, e.idx, e.result, e.err, e.tmo);
    end
  endtask

  task automatic test_timeout;
    exp_t e;
    int g, gi, c;
    bit seen;
    apply_reset();
    dp_mode = 0; dp_delay = 2;
    set_req(3, 16'd1, 16'd1, 2'd2);
    req_valid = 4'b1000;
    sb.push_back('{idx: 3, result: 16'd0, err: 1'b0, tmo: 1'b1});
    wait_ready(5, g);
    req_valid = '0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (dp_start) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("[TB] FAIL tmo_start: got no start expected start pulse");
    end
    wait_rsp(100, gi, c);
    checks++;
    if (c != TIMEOUT) begin
      errors++; $display("[TB] FAIL tmo_latency: got %0d cycles expected %0d", c, TIMEOUT);
    end
    checks++;
    e = sb.pop_front();
    if (gi != e.idx || rsp_result !== e.result || rsp_error !== e.err || rsp_timeout !== e.tmo) begin
      errors++;
      $display("[TB] FAIL tmo_rsp: got req=%0d res=%0d err=%b tmo=%b expected req=%0d res=%0d err=%b tmo=%b",
               gi, rsp_result, rsp_error, rsp_timeout, e.idx, e.result, e.err, e.tmo);
    end
    dp_mode = 1;
    set_req(0, 16'd2, 16'd3, 2'd1);
    req_valid = 4'b0001;
    sb.push_back('{idx: 0, result: 16'd6, err: 1'b0, tmo: 1'b0});
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000) begin
      errors++; $display("[TB] FAIL tmo_idle: got ready=%b rsp=%b expected 0000 0000", req_ready, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("[TB] FAIL tmo_regrant: got %b expected 0001", req_ready);
    end
    req_valid = '0;
    wait_rsp(20, gi, c);
    checks++;
    e = sb.pop_front();
    if (gi != e.idx || rsp_result !== e.result || rsp_error !== e.err || rsp_timeout !== e.tmo) begin
      errors++;
      $display("[TB] FAIL tmo_next_rsp: got req=%0d res=%0d err=%b tmo=%b expected req=%0d res=%0d err=%b tmo=%b",
               gi, rsp_result, rsp_error, rsp_timeout, e.idx, e.result, e.err, e.tmo);
    end
  endtask

  task automatic test_reset_mid_op;
    exp_t e;
    int g, gi, c;
    bit stray;
    apply_reset();
    dp_mode = 0; dp_delay = 2;
    set_req(2, 16'd4, 16'd4, 2'd1);
    req_valid = 4'b0100;
    wait_ready(5, g);
    req_valid = '0;
    repeat (10) @(negedge clk);
    checks++;
    if (dp_op_sel !== 2'd1) begin
      errors++; $display("[TB] FAIL midrst_busy: got op_sel=%0d expected 1", dp_op_sel);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_result, rsp_error, rsp_timeout, dp_operand, dp_load_x, dp_load_y, dp_op_sel, dp_start} !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_async: got ready=%b rsp=%b op_sel=%0d st=%b expected all 0", req_ready, rsp_valid, dp_op_sel, dp_start);
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (rsp_valid != '0 || req_ready != '0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++; $display("[TB] FAIL midrst_no_rsp: got activity=1 expected 0");
    end
    dp_mode = 1;
    set_req(0, 16'd10, 16'd3, 2'd2);
    set_req(3, 16'd8, 16'd8, 2'd0);
    sb.push_back('{idx: 0, result: 16'd7, err: 1'b0, tmo: 1'b0});
    sb.push_back('{idx: 3, result: 16'd16, err: 1'b0, tmo: 1'b0});
    req_valid = 4'b1001;
    wait_ready(5, g);
    checks++;
    if (g != 0) begin
      errors++; $display("[TB] FAIL midrst_ptr: got grant %0d expected 0", g);
    end
    req_valid = 4'b1000;
    for (int j = 0; j < 2; j++) begin
      wait_rsp(20, gi, c);
      checks++;
      e = sb.pop_front();
      if (gi != e.idx || rsp_result !== e.result || rsp_error !== e.err || rsp_timeout !== e.tmo) begin
        errors++;
        $display("[TB] FAIL midrst_rsp%0d: got req=%0d res=%0d err=%b tmo=%b expected req=%0d res=%0d err=%b tmo=%b",
                 j, gi, rsp_result, rsp_error, rsp_timeout, e.idx, e.result, e.err, e.tmo);
      end
      if (j == 0) begin
        wait_ready(5, g);
        req_valid = '0;
      end
    end
  endtask

  task automatic test_spurious;
    exp_t e;
    int g, gi, c;
    bit stray;
    apply_reset();
    dp_mode = 1; dp_delay = 2;
    stray = 1'b0;
    spur_done = 1'b1;
    spur_error = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid != '0 || req_ready != '0 || dp_load_x || dp_start) stray = 1'b1;
    end
    spur_done = 1'b0;
    spur_error = 1'b0;
    @(negedge clk);
    req_valid = 4'b0010;
    #2 req_valid = '0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid != '0 || req_ready != '0 || dp_load_x || dp_start) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++; $display("[TB] FAIL spurious_quiet: got activity=1 expected 0");
    end
    set_req(1, 16'd20, 16'd4, 2'd3);
    sb.push_back('{idx: 1, result: 16'd16, err: 1'b0, tmo: 1'b0});
    req_valid = 4'b0010;
    wait_ready(5, g);
    req_valid = '0;
    wait_rsp(20, gi, c);
    checks++;
    e = sb.pop_front();
    if (gi != e.idx || rsp_result !== e.result || rsp_error !== e.err || rsp_timeout !== e.tmo) begin
      errors++;
      $display("[TB] FAIL spurious_next_rsp: got req=%0d res=%0d err=%b tmo=%b expected req=%0d res=%0d err=%b tmo=%b",
               gi, rsp_result, rsp_error, rsp_timeout, e.idx, e.result, e.err, e.tmo);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    req_op = '0;
    dp_mode = 1;
    dp_delay = 2;
    spur_done = 1'b0;
    spur_error = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_error_priority();
    test_timeout();
    test_reset_mid_op();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
